// File: rtl/dec_pkg.sv
// Shared types and helpers for the streaming 2-to-4 decoder.
package dec_pkg;

    localparam int CODE_W   = 2;
    localparam int ONEHOT_W = 4;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // One-hot decode of a code. A disabled decode produces the all-zero word.
    function automatic logic [ONEHOT_W-1:0] code2onehot(input logic [CODE_W-1:0] code,
                                                        input logic              en);
        logic [ONEHOT_W-1:0] y;
        y = '0;
        if (en) begin
            y[code] = 1'b1;
        end
        return y;
    endfunction

endpackage

// File: rtl/dec_skid2.sv
// Two-entry FIFO skid buffer with valid/ready on both sides.
// in_ready depends only on the registered occupancy, so there is no
// combinational path from out_ready to in_ready.
module dec_skid2
    import dec_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_t         state;
    occ_t         next_state;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Occupancy register; reset discards both entries immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Occupancy transitions driven by push/pop
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: if (push)              next_state = ONE;
            ONE: begin
                if (push && !pop)         next_state = TWO;
                else if (pop && !push)    next_state = EMPTY;
            end
            TWO:   if (pop)               next_state = ONE;
            default:                      next_state = EMPTY;
        endcase
    end

    // Handshake outputs; the word is forced to zero whenever nothing is held
    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
        out_data  = (state != EMPTY) ? head : '0;
    end

    // Entry storage: the head always holds the oldest word, and the second entry moves up on a pop from full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) head <= in_data;
                end
                ONE: begin
                    if (push && pop)  head <= in_data;
                    else if (push)    tail <= in_data;
                end
                TWO: begin
                    if (pop) head <= tail;
                end
                default: begin
                    head <= head;
                end
            endcase
        end
    end

endmodule

// File: rtl/dec2x4_stream.sv
// Streaming 2-to-4 one-hot decoder with enable and a built-in scan source.
// The scan source walks codes 0..3, pushing one every SCAN_DWELL cycles and
// waiting (dwell held) while the buffer is full so no code is ever skipped.
module dec2x4_stream
    import dec_pkg::*;
#(
    parameter int SCAN_DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                scan,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ONEHOT_W-1:0] out_y,
    output logic                scan_wrap
);

    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DWELL - 1);

    logic [7:0]          dwell;
    logic [CODE_W-1:0]   scan_code;
    logic                scan_fire;
    logic                buf_ready;
    logic                src_valid;
    logic [CODE_W-1:0]   src_code;
    logic [ONEHOT_W-1:0] push_data;

    // Source select and enable gating; the scan push only fires when the buffer has room
    always_comb begin
        scan_fire = scan && (dwell == DWELL_LAST) && buf_ready;
        src_valid = scan ? scan_fire : in_valid;
        src_code  = scan ? scan_code : in_code;
        push_data = code2onehot(src_code, en);
        in_ready  = buf_ready && !scan;
    end

    // Scan counters and the wrap pulse; everything idles at zero outside scan mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell     <= '0;
            scan_code <= '0;
            scan_wrap <= 1'b0;
        end else if (!scan) begin
            dwell     <= '0;
            scan_code <= '0;
            scan_wrap <= 1'b0;
        end else begin
            scan_wrap <= scan_fire && (scan_code == 2'd3);
            if (scan_fire) begin
                dwell     <= '0;
                scan_code <= scan_code + 2'd1;
            end else if (dwell != DWELL_LAST) begin
                dwell <= dwell + 8'd1;
            end
        end
    end

    dec_skid2 #(.W(ONEHOT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (src_valid),
        .in_ready  (buf_ready),
        .in_data   (push_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_y)
    );

endmodule

// File: tb/tb_dec2x4_stream.sv
// Self-checking bench for dec2x4_stream with a word scoreboard.
module tb_dec2x4_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       scan;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_y;
    logic       scan_wrap;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];

    dec2x4_stream #(.SCAN_DWELL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .scan      (scan),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .scan_wrap (scan_wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_word(input logic [1:0] code, input logic e);
        logic [3:0] table_w [4];
        table_w[0] = 4'b0001;
        table_w[1] = 4'b0010;
        table_w[2] = 4'b0100;
        table_w[3] = 4'b1000;
        return e ? table_w[code] : 4'b0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop/compare on an output handshake, push on an accepted external input
    task automatic checkOutput();
        logic [3:0] exp_w;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("[TB] FAIL sb_unexpected observed=%0h expected=none", out_y);
            end
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("sb_word", {28'd0, out_y}, {28'd0, exp_w});
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1 && scan === 1'b0) begin
            exp_q.push_back(model_word(in_code, en));
        end
    endtask

    // One clock: sample handshakes mid-cycle, then move to just after the edge
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        scan      = 1'b0;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        out_ready = 1'b1;

        // Reset values
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_y", {28'd0, out_y}, 32'd0);
        check("rst_scan_wrap", {31'd0, scan_wrap}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        scan = 1'b1;
        #1;
        check("rst_in_ready_scan", {31'd0, in_ready}, 32'd0);
        scan = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus();

        // Back-to-back codes 0..3, one cycle latency, no bubbles
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_code  = 2'(c);
            applyStimulus();
            check("b2b_valid", {31'd0, out_valid}, 32'd1);
            check("b2b_word", {28'd0, out_y}, {28'd0, model_word(2'(c), 1'b1)});
        end
        in_valid = 1'b0;
        applyStimulus();
        check("b2b_drained", {31'd0, out_valid}, 32'd0);

        // en=0 stores zero; a later en change leaves the stored word alone
        en        = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd2;
        applyStimulus();
        in_valid = 1'b0;
        en       = 1'b1;
        applyStimulus();
        check("en0_valid", {31'd0, out_valid}, 32'd1);
        check("en0_word", {28'd0, out_y}, 32'd0);
        out_ready = 1'b1;
        applyStimulus();
        check("en0_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: two words fill the buffer, a third is refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd1;
        applyStimulus();
        check("bp_ready_one", {31'd0, in_ready}, 32'd1);
        in_code = 2'd3;
        applyStimulus();
        check("bp_ready_full", {31'd0, in_ready}, 32'd0);
        in_code = 2'd0;
        applyStimulus();
        applyStimulus();
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        check("bp_stable", {28'd0, out_y}, 32'h2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        applyStimulus();
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        check("bp_second", {28'd0, out_y}, 32'h8);
        applyStimulus();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Scan cadence with SCAN_DWELL=4; expected words known in order up front
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        scan = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            in_valid = ~in_valid;
            in_code  = 2'($urandom_range(0, 3));
            applyStimulus();
            check("scan_valid", {31'd0, out_valid}, (k % 4 == 0) ? 32'd1 : 32'd0);
            check("scan_wrap", {31'd0, scan_wrap}, (k == 16) ? 32'd1 : 32'd0);
            check("scan_in_ready", {31'd0, in_ready}, 32'd0);
        end

        // Scan under backpressure: two words held, dwell waits
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = ~in_valid;
            applyStimulus();
        end
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_head", {28'd0, out_y}, 32'h1);
        check("hold_left", exp_q.size(), 32'd3);
        out_ready = 1'b1;
        applyStimulus();
        check("hold_pop1", {28'd0, out_y}, 32'h2);
        applyStimulus();
        check("hold_immediate", {28'd0, out_y}, 32'h4);
        check("hold_immediate_v", {31'd0, out_valid}, 32'd1);
        scan     = 1'b0;
        in_valid = 1'b0;
        applyStimulus();
        check("scan_off_drained", {31'd0, out_valid}, 32'd0);
        check("scan_off_wrap", {31'd0, scan_wrap}, 32'd0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd2;
        applyStimulus();
        in_code = 2'd1;
        applyStimulus();
        in_valid = 1'b0;
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_word", {28'd0, out_y}, 32'd0);
        exp_q.delete();
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 2'd1;
        applyStimulus();
        in_valid = 1'b0;
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_word", {28'd0, out_y}, 32'h2);
        applyStimulus();
        check("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dec2x4_stream.md
# dec2x4_stream

Streaming 2-to-4 one-hot decoder with enable, the inverse of the team's 4-to-2 encoder. It accepts 2-bit codes on a valid/ready input, registers them through a 2-entry skid buffer, and presents the 4-bit one-hot word on a valid/ready output. A built-in scan mode generates codes 0..3 on its own, so the decoder can drive the encoder in loopback benches without an external stimulus source.

## Interface
- SCAN_DWELL, default 4: cycles between scan-mode pushes; legal range 1..255.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  decode enable; sampled at push time; 0 stores 4'b0000.
- scan  input  1  1 = internal scan source; in_code/in_valid are ignored.
- in_valid  input  1  in_code is valid.
- in_ready  output  1  decoder accepts in_code this cycle.
- in_code  input  2  code to decode.
- out_valid  output  1  out_y holds a decoded word.
- out_ready  input  1  downstream accepts out_y.
- out_y  output  4  one-hot word, 4'b0001 << code; 4'b0000 when captured with en=0.
- scan_wrap  output  1  1-cycle pulse on the cycle after a scan push of code 3.

## Operation
- Occupancy state machine with three states:
  - EMPTY -> ONE on a push.
  - ONE -> TWO on a push without a pop.
  - ONE -> EMPTY on a pop without a push.
  - ONE -> ONE on a push and a pop together.
  - TWO -> ONE on a pop.
- Push = selected source valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (state != TWO) && !scan. It is derived combinationally from registered state only and never depends on in_valid or out_ready.
- out_valid = (state != EMPTY). out_y is the head entry.
- Buffer order is FIFO. When the head pops in TWO, the second entry becomes the head on the same edge.
- Push data is en ? (4'b0001 << code) : 4'b0000. en is sampled only when the push occurs; entries already stored are unaffected by later changes to en.
- Scan mode:
  - Uses a dwell counter (8 bits) and a code counter (2 bits).
  - The internal push fires when dwell == SCAN_DWELL-1 and state != TWO.
  - A push clears dwell and increments the code counter, wrapping 3 -> 0.
  - If dwell reaches SCAN_DWELL-1 while the buffer is full, dwell holds and the push fires on the first cycle the buffer is not full.
  - scan_wrap is registered and goes high for 1 cycle after the edge that pushes code 3.
- With scan=0, both scan counters are held at 0 and scan_wrap is 0.
- Switching scan mid-stream does not flush the buffer. Entries already stored still drain normally.

## Timing
- Reset values: state EMPTY, out_valid 0, out_y 4'b0000, scan_wrap 0, both scan counters 0. in_ready = !scan during reset.
- Latency: a code accepted at edge N is on out_y with out_valid=1 in the cycle after edge N.
- Throughput is 1 word per cycle when out_ready is held high.
- out_y and out_valid are stable while out_valid=1 && out_ready=0.
- Backpressure: with out_ready=0, two words are accepted, then in_ready drops in the cycle after the second push.
- Scan cadence, out_ready=1: first push at the edge ending cycle SCAN_DWELL after reset release, then one push every SCAN_DWELL cycles. With SCAN_DWELL=1 there is one push per cycle.
- Reset mid-operation: buffer contents are discarded immediately and asynchronously. out_valid falls without waiting for a clock edge.

## Structure
- Package dec_pkg holds:
  - CODE_W=2 and ONEHOT_W=4.
  - An occupancy state typedef with EMPTY, ONE and TWO.
  - Function code2onehot(code, en).
- Sub-module dec_skid2 is the 2-entry valid/ready buffer, parameterised on data width. The top level holds the source mux, the en gating and the scan counters.

## Test plan
- en=1; codes 0,1,2,3 pushed back-to-back; out_ready=1 -> out_y = 0001, 0010, 0100, 1000, each one cycle after its push; no bubbles.
- en=0; code 2 pushed -> out_y=0000 with out_valid=1. en rises after the push -> the stored word stays 0000.
- out_ready=0; push codes 1 and 3 -> in_ready=0 after the second push; a third in_valid is not accepted. Then out_ready=1 -> 0010, then 1000, and in_ready returns to 1.
- scan=1, SCAN_DWELL=4, out_ready=1 -> pushes every 4 cycles with out_y cycling 0001, 0010, 0100, 1000, 0001; scan_wrap pulses once per cycle of four. in_valid toggling has no effect.
- scan=1 with out_ready=0 for 20 cycles -> exactly 2 words buffered and dwell held. On release, the next code pushes immediately with no skipped codes.
- rst asserted while state is TWO -> out_valid=0 and out_y=0000 with no clock edge. After release, a fresh code 1 -> out_y=0010.
